taillight_decoder: RTL and testbench

Receive-side checker for the 6-lamp sequential tail-light pattern bus produced by the tail-light state machine. It samples the pre-dim pattern on a step strobe and tracks each 3-lamp half independently. It classifies the active mode (idle, left, right, brake, hazard, turn+brake) and flags illegal lamp transitions. It sits in the self-check/monitor path beside the tail-light top and feeds status LEDs or a bench scoreboard.

---
 rtl/taillight_pkg.sv | 59 +++++
 rtl/taillight_decoder_side_tracker.sv | 83 ++++++++
 rtl/taillight_decoder.sv | 79 +++++++
 tb/tb_taillight_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/taillight_pkg.sv
// Shared types and helpers for the tail-light pattern decoder.
// Halves are handled in normalised inner-to-outer order {outer, middle, inner}.
package taillight_pkg;

  typedef enum logic [2:0] {
    MODE_UNKNOWN = 3'd0,
    IDLE         = 3'd1,
    LEFT         = 3'd2,
    RIGHT        = 3'd3,
    BRAKE        = 3'd4,
    HAZARD       = 3'd5,
    LEFT_BRAKE   = 3'd6,
    RIGHT_BRAKE  = 3'd7
  } mode_t;

  typedef enum logic [2:0] {
    K_UNK   = 3'd0,
    K_OFF   = 3'd1,
    K_SOLID = 3'd2,
    K_SEQ   = 3'd3,
    K_BLINK = 3'd4
  } kind_t;

  // T_CONT is the all-lamps-off gap inside a sequence or blink run.
  typedef enum logic [2:0] {
    T_OFF   = 3'd0,
    T_SOLID = 3'd1,
    T_SEQ   = 3'd2,
    T_BLINK = 3'd3,
    T_CONT  = 3'd4,
    T_BAD   = 3'd5
  } trans_t;

  localparam logic [2:0] H_OFF = 3'b000;
  localparam logic [2:0] H_ALL = 3'b111;

  function automatic trans_t classify(logic [2:0] p, logic [2:0] n);
    if (p == H_OFF && n == H_OFF) return T_OFF;
    if (p == H_ALL && n == H_ALL) return T_SOLID;
    if (p == H_OFF && n == H_ALL) return T_BLINK;
    if (p == H_ALL && n == H_OFF) return T_CONT;
    if ((p == 3'b000 && n == 3'b001) ||
        (p == 3'b001 && n == 3'b011) ||
        (p == 3'b011 && n == 3'b111)) return T_SEQ;
    return T_BAD;
  endfunction

  function automatic mode_t combine(kind_t l, kind_t r, logic same);
    if (l == K_OFF   && r == K_OFF)   return IDLE;
    if (l == K_SEQ   && r == K_OFF)   return LEFT;
    if (l == K_OFF   && r == K_SEQ)   return RIGHT;
    if (l == K_SOLID && r == K_SOLID) return BRAKE;
    if (l == K_SEQ   && r == K_SOLID) return LEFT_BRAKE;
    if (l == K_SOLID && r == K_SEQ)   return RIGHT_BRAKE;
    if (l == K_BLINK && r == K_BLINK && same) return HAZARD;
    return MODE_UNKNOWN;
  endfunction

endpackage

// File: rtl/taillight_decoder_side_tracker.sv
// Per-half run tracker: classifies each sampled transition, keeps a saturating
// run count and reports the half's class once the run is confirmed.
module side_tracker
  import taillight_pkg::*;
#(
  parameter int CONFIRM = 3,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [2:0] half,
  output kind_t      cls,
  output logic       err
);

  localparam logic [CW-1:0] CMAX = CW'(CONFIRM);

  logic [2:0]    prev;
  kind_t         kind;
  logic [CW-1:0] cnt;

  trans_t        tr;
  kind_t         tk;
  kind_t         kind_nx;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic          bad;

  assign cnt_inc = (cnt >= CMAX) ? CMAX : cnt + CW'(1);

  always_comb begin
    tr      = classify(prev, half);
    tk      = K_UNK;
    kind_nx = kind;
    cnt_nx  = cnt;
    bad     = 1'b0;
    case (tr)
      T_OFF:   tk = K_OFF;
      T_SOLID: tk = K_SOLID;
      T_SEQ:   tk = K_SEQ;
      T_BLINK: tk = K_BLINK;
      default: tk = K_UNK;
    endcase
    if (tr == T_BAD) begin
      kind_nx = K_UNK;
      cnt_nx  = '0;
      bad     = 1'b1;
    end else if (tr == T_CONT) begin
      // The dark gap only extends runs that naturally contain it.
      if (kind == K_SEQ || kind == K_BLINK) begin
        cnt_nx = cnt_inc;
      end else begin
        kind_nx = K_UNK;
        cnt_nx  = '0;
      end
    end else if (tk == kind) begin
      cnt_nx = cnt_inc;
    end else begin
      kind_nx = tk;
      cnt_nx  = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= H_OFF;
      kind <= K_UNK;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      err <= step & bad;
      if (step) begin
        prev <= half;
        kind <= kind_nx;
        cnt  <= cnt_nx;
      end
    end
  end

  assign cls = (cnt >= CMAX) ? kind : K_UNK;

endmodule

// File: rtl/taillight_decoder.sv
// Tail-light pattern monitor: normalises both halves, tracks them independently
// and registers the combined mode, change pulse and sequence-error pulse.
module taillight_decoder
  import taillight_pkg::*;
#(
  parameter int CONFIRM = 3,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [5:0] pattern,
  output mode_t      mode,
  output logic       mode_valid,
  output logic       mode_chg,
  output logic       seq_error
);

  logic [2:0] n_l;
  logic [2:0] n_r;
  logic [2:0] last_l;
  logic [2:0] last_r;
  logic       step_d;
  kind_t      cls_l;
  kind_t      cls_r;
  logic       err_l;
  logic       err_r;
  mode_t      mode_nx;

  // Right half is mirrored so both trackers see inner lamp at bit 0.
  assign n_l = pattern[5:3];
  assign n_r = {pattern[0], pattern[1], pattern[2]};

  side_tracker #(.CONFIRM(CONFIRM), .CW(CW)) u_left (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .half (n_l),
    .cls  (cls_l),
    .err  (err_l)
  );

  side_tracker #(.CONFIRM(CONFIRM), .CW(CW)) u_right (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .half (n_r),
    .cls  (cls_r),
    .err  (err_r)
  );

  assign mode_nx = combine(cls_l, cls_r, last_l == last_r);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_l     <= H_OFF;
      last_r     <= H_OFF;
      step_d     <= 1'b0;
      mode       <= MODE_UNKNOWN;
      mode_valid <= 1'b0;
      mode_chg   <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      step_d    <= step;
      seq_error <= err_l | err_r;
      mode_chg  <= 1'b0;
      if (step) begin
        last_l <= n_l;
        last_r <= n_r;
      end
      if (step_d) begin
        mode       <= mode_nx;
        mode_valid <= (mode_nx != MODE_UNKNOWN);
        mode_chg   <= (mode_nx != mode);
      end
    end
  end

endmodule

// File: tb/tb_taillight_decoder.sv
// Directed-vector bench for taillight_decoder (CONFIRM=3) with hand-derived
// expected mode / pulse values per step.
module tb_taillight_decoder;
  import taillight_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic [5:0] pattern = 6'b0;
  mode_t      mode;
  logic       mode_valid;
  logic       mode_chg;
  logic       seq_error;

  int n_cmp = 0;
  int n_bad = 0;

  taillight_decoder #(.CONFIRM(3), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .pattern    (pattern),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_chg   (mode_chg),
    .seq_error  (seq_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] em, input logic ec, input logic ee);
    chk({tag, ".mode"},  8'(mode), 8'(em));
    chk({tag, ".valid"}, 8'(mode_valid), 8'(em != 3'd0));
    chk({tag, ".chg"},   8'(mode_chg), 8'(ec));
    chk({tag, ".err"},   8'(seq_error), 8'(ee));
  endtask

  // One step strobe; outputs checked after the second edge, then pulses must drop.
  task automatic step_chk(input string tag, input logic [5:0] p,
                          input logic [2:0] em, input logic ec, input logic ee);
    @(negedge clk);
    step    = 1'b1;
    pattern = p;
    @(negedge clk);
    step = 1'b0;
    @(posedge clk);
    #1;
    check_outs(tag, em, ec, ee);
    @(posedge clk);
    #1;
    check_outs({tag, ".after"}, em, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outs("reset", 3'd0, 1'b0, 1'b0);
    rst = 1'b1;

    // left turn, gap continuation, illegal step and recovery
    step_chk("l1", 6'b001000, 3'd0, 1'b0, 1'b0);
    step_chk("l2", 6'b011000, 3'd0, 1'b0, 1'b0);
    step_chk("l3", 6'b111000, 3'd2, 1'b1, 1'b0);
    step_chk("l4", 6'b000000, 3'd2, 1'b0, 1'b0);
    step_chk("l5", 6'b001000, 3'd2, 1'b0, 1'b0);
    step_chk("bad1", 6'b101000, 3'd0, 1'b1, 1'b1);
    step_chk("bad2", 6'b000000, 3'd0, 1'b0, 1'b1);
    step_chk("r1", 6'b001000, 3'd0, 1'b0, 1'b0);
    step_chk("r2", 6'b011000, 3'd0, 1'b0, 1'b0);
    step_chk("r3", 6'b111000, 3'd2, 1'b1, 1'b0);

    // reset together with step during LEFT; history must be discarded
    @(negedge clk);
    rst     = 1'b0;
    step    = 1'b1;
    pattern = 6'b000000;
    @(posedge clk);
    #1;
    check_outs("midrst", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
    step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("midrst.hold", 3'd0, 1'b0, 1'b0);
    step_chk("h1", 6'b001000, 3'd0, 1'b0, 1'b0);
    step_chk("h2", 6'b011000, 3'd0, 1'b0, 1'b0);
    step_chk("h3", 6'b111000, 3'd2, 1'b1, 1'b0);

    // brake, release to unknown without error, then idle
    do_reset();
    step_chk("b1", 6'b111111, 3'd0, 1'b0, 1'b0);
    step_chk("b2", 6'b111111, 3'd0, 1'b0, 1'b0);
    step_chk("b3", 6'b111111, 3'd0, 1'b0, 1'b0);
    step_chk("b4", 6'b111111, 3'd4, 1'b1, 1'b0);
    step_chk("b5", 6'b000000, 3'd0, 1'b1, 1'b0);
    step_chk("i1", 6'b000000, 3'd0, 1'b0, 1'b0);
    step_chk("i2", 6'b000000, 3'd0, 1'b0, 1'b0);
    step_chk("i3", 6'b000000, 3'd1, 1'b1, 1'b0);

    // hazard in phase, then broken
    do_reset();
    step_chk("z1", 6'b111111, 3'd0, 1'b0, 1'b0);
    step_chk("z2", 6'b000000, 3'd0, 1'b0, 1'b0);
    step_chk("z3", 6'b111111, 3'd5, 1'b1, 1'b0);
    step_chk("z4", 6'b000000, 3'd5, 1'b0, 1'b0);
    step_chk("z5", 6'b111111, 3'd5, 1'b0, 1'b0);
    step_chk("z6", 6'b111000, 3'd0, 1'b1, 1'b0);

    // both halves blinking but out of phase is not hazard
    do_reset();
    step_chk("p1", 6'b111000, 3'd0, 1'b0, 1'b0);
    step_chk("p2", 6'b000111, 3'd0, 1'b0, 1'b0);
    step_chk("p3", 6'b111000, 3'd0, 1'b0, 1'b0);
    step_chk("p4", 6'b000111, 3'd0, 1'b0, 1'b0);
    step_chk("p5", 6'b111000, 3'd0, 1'b0, 1'b0);

    // right turn while braking
    do_reset();
    step_chk("rb1", 6'b111100, 3'd0, 1'b0, 1'b0);
    step_chk("rb2", 6'b111110, 3'd0, 1'b0, 1'b0);
    step_chk("rb3", 6'b111111, 3'd0, 1'b0, 1'b0);
    step_chk("rb4", 6'b111000, 3'd7, 1'b1, 1'b0);
    step_chk("rb5", 6'b111100, 3'd7, 1'b0, 1'b0);

    // plain right turn
    do_reset();
    step_chk("rt1", 6'b000100, 3'd0, 1'b0, 1'b0);
    step_chk("rt2", 6'b000110, 3'd0, 1'b0, 1'b0);
    step_chk("rt3", 6'b000111, 3'd3, 1'b1, 1'b0);

    // left turn while braking
    do_reset();
    step_chk("lb1", 6'b000111, 3'd0, 1'b0, 1'b0);
    step_chk("lb2", 6'b000111, 3'd0, 1'b0, 1'b0);
    step_chk("lb3", 6'b001111, 3'd0, 1'b0, 1'b0);
    step_chk("lb4", 6'b011111, 3'd0, 1'b0, 1'b0);
    step_chk("lb5", 6'b111111, 3'd6, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
